// File: rtl/dual_issue_decode_stage_pkg.sv
// Shared encodings for the dual-issue decode stage: RV32I opcode/funct fields,
// ALU op and branch-type codes, per-lane decode record and the mode FSM states.
package dual_issue_decode_stage_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_AND   = 3'b001,
    ALU_OR    = 3'b010,
    ALU_XOR   = 3'b011,
    ALU_SHIFT = 3'b100,
    ALU_CMP   = 3'b101
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b010,
    BR_GE  = 3'b011,
    BR_LTU = 3'b100,
    BR_GEU = 3'b101
  } br_type_e;

  typedef enum logic [1:0] {
    S_NORMAL = 2'b00,
    S_DRAIN  = 2'b01,
    S_SWITCH = 2'b10
  } state_e;

  typedef struct packed {
    alu_op_e  alu_op;
    logic     alu_src;
    logic     sub;
    logic     shift_right;
    logic     shift_arith;
    logic     mem_write;
    logic     branch;
    br_type_e branch_type;
    logic     illegal;
  } dec_t;

  function automatic alu_op_e alu_op_of(input logic [2:0] f3);
    case (f3)
      3'b000:         return ALU_ADD;
      3'b001, 3'b101: return ALU_SHIFT;
      3'b010, 3'b011: return ALU_CMP;
      3'b100:         return ALU_XOR;
      3'b110:         return ALU_OR;
      default:        return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/dual_issue_decode_stage_if.sv
// Bundle handshake, mode control and decoded-field bus of the decode stage.
interface dual_issue_decode_stage_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES-1:0]         in_lane_valid;
  logic [32*LANES-1:0]      in_instr;
  logic                     mode_i;
  logic                     mode_q;
  logic                     mode_busy;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES-1:0]         out_lane_valid;
  logic [3*LANES-1:0]       out_alu_op;
  logic [LANES-1:0]         out_alu_src;
  logic [LANES-1:0]         out_sub;
  logic [LANES-1:0]         out_shift_right;
  logic [LANES-1:0]         out_shift_arith;
  logic [LANES-1:0]         out_mem_write;
  logic [LANES-1:0]         out_branch;
  logic [3*LANES-1:0]       out_branch_type;
  logic [LANES-1:0]         out_illegal;
  logic [CNT_W*LANES-1:0]   illegal_cnt;

  modport slave (
    input  in_valid, in_lane_valid, in_instr, mode_i, out_ready,
    output in_ready, mode_q, mode_busy, out_valid, out_lane_valid, out_alu_op,
           out_alu_src, out_sub, out_shift_right, out_shift_arith, out_mem_write,
           out_branch, out_branch_type, out_illegal, illegal_cnt
  );

  modport master (
    output in_valid, in_lane_valid, in_instr, mode_i, out_ready,
    input  in_ready, mode_q, mode_busy, out_valid, out_lane_valid, out_alu_op,
           out_alu_src, out_sub, out_shift_right, out_shift_arith, out_mem_write,
           out_branch, out_branch_type, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/dual_issue_decode_stage_lane_decoder.sv
// Combinational single-lane RV32I decoder; an undecodable word yields only illegal=1.
module lane_decoder
  import dual_issue_decode_stage_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_illegal;
  logic       w_unused_bits;

  assign w_opcode      = i_instr[6:0];
  assign w_f3          = i_instr[14:12];
  assign w_f7          = i_instr[31:25];
  assign w_unused_bits = ^{i_instr[24:15], i_instr[11:7]};

  always_comb begin
    o_dec     = '0;
    w_illegal = 1'b0;
    case (w_opcode)
      OP_R: begin
        if (w_f7 != F7_BASE && w_f7 != F7_ALT)
          w_illegal = 1'b1;
        else if (w_f7 == F7_ALT && w_f3 != F3_ADD_SUB && w_f3 != F3_SR)
          w_illegal = 1'b1;
        o_dec.alu_op      = alu_op_of(w_f3);
        o_dec.sub         = (w_f7 == F7_ALT) && (w_f3 == F3_ADD_SUB);
        o_dec.shift_right = (w_f3 == F3_SR);
        o_dec.shift_arith = (w_f3 == F3_SR) && i_instr[30];
      end
      OP_I: begin
        o_dec.alu_src     = 1'b1;
        o_dec.alu_op      = alu_op_of(w_f3);
        o_dec.shift_right = (w_f3 == F3_SR);
        o_dec.shift_arith = (w_f3 == F3_SR) && i_instr[30];
      end
      OP_LOAD, OP_JALR: o_dec.alu_src = 1'b1;
      OP_STORE: begin
        o_dec.alu_src   = 1'b1;
        o_dec.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        o_dec.branch = 1'b1;
        case (w_f3)
          3'b000:  o_dec.branch_type = BR_EQ;
          3'b001:  o_dec.branch_type = BR_NE;
          3'b100:  o_dec.branch_type = BR_LT;
          3'b101:  o_dec.branch_type = BR_GE;
          3'b110:  o_dec.branch_type = BR_LTU;
          3'b111:  o_dec.branch_type = BR_GEU;
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      o_dec         = '0;
      o_dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/dual_issue_decode_stage.sv
// Registered N-lane decode stage with split/unified mode FSM that drains the
// output register before switching, plus saturating per-lane illegal counters.
module dual_issue_decode_stage
  import dual_issue_decode_stage_pkg::*;
#(
  parameter int unsigned LANES      = 2,
  parameter int unsigned CNT_W      = 8,
  parameter logic        RESET_MODE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  dual_issue_decode_stage_if.slave bus
);

  state_e           r_state, w_state_nxt;
  logic             r_mode_q;
  logic             r_out_valid;
  logic [LANES-1:0] r_lane_vld;
  logic [LANES-1:0] w_lane_vld;
  dec_t             w_dec [LANES];
  dec_t             r_dec [LANES];
  logic [CNT_W-1:0] r_cnt [LANES];
  logic             w_in_ready;
  logic             w_accept;

  assign w_in_ready = (r_state == S_NORMAL) && (bus.mode_i == r_mode_q) &&
                      (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  assign bus.in_ready       = w_in_ready;
  assign bus.mode_q         = r_mode_q;
  assign bus.mode_busy      = (r_state != S_NORMAL);
  assign bus.out_valid      = r_out_valid;
  assign bus.out_lane_valid = r_lane_vld;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_decoder u_dec (
      .i_instr (bus.in_instr[g*32 +: 32]),
      .o_dec   (w_dec[g])
    );
    // Unified mode runs only lane 0; upper lanes are masked before counting and registering.
    if (g == 0) begin : g_l0
      assign w_lane_vld[g] = bus.in_lane_valid[g];
    end else begin : g_ln
      assign w_lane_vld[g] = bus.in_lane_valid[g] && !r_mode_q;
    end
    assign bus.out_alu_op[g*3 +: 3]      = r_dec[g].alu_op;
    assign bus.out_alu_src[g]            = r_dec[g].alu_src;
    assign bus.out_sub[g]                = r_dec[g].sub;
    assign bus.out_shift_right[g]        = r_dec[g].shift_right;
    assign bus.out_shift_arith[g]        = r_dec[g].shift_arith;
    assign bus.out_mem_write[g]          = r_dec[g].mem_write;
    assign bus.out_branch[g]             = r_dec[g].branch;
    assign bus.out_branch_type[g*3 +: 3] = r_dec[g].branch_type;
    assign bus.out_illegal[g]            = r_dec[g].illegal;
    assign bus.illegal_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_NORMAL: if (bus.mode_i != r_mode_q) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (!r_out_valid || bus.out_ready) w_state_nxt = S_SWITCH;
      S_SWITCH: w_state_nxt = S_NORMAL;
      default:  w_state_nxt = S_NORMAL;
    endcase
  end

  // mode_q samples mode_i in SWITCH, so a request reverted during DRAIN is a no-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_NORMAL;
      r_mode_q <= RESET_MODE;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_SWITCH) r_mode_q <= bus.mode_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_lane_vld  <= '0;
      for (int unsigned i = 0; i < LANES; i++) r_dec[i] <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_lane_vld  <= w_lane_vld;
      for (int unsigned i = 0; i < LANES; i++)
        r_dec[i] <= w_lane_vld[i] ? w_dec[i] : '0;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LANES; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++)
        if (w_accept && w_lane_vld[i] && w_dec[i].illegal && (r_cnt[i] != '1))
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
    end
  end

endmodule

// File: doc/dual_issue_decode_stage.md
# dual_issue_decode_stage

Registered, parametrised N-lane instruction decode stage for the split/unified ALU datapath. Takes one bundle of up to `LANES` RV32I instruction words per transaction and emits per-lane control fields one cycle later through a valid/ready handshake. It owns the split/unified mode register and drains in-flight work before any mode change. Per-lane saturating illegal-instruction counters support debug. It sits between the fetch/issue buffer and the ALU/branch/memory stages.

## Interface
- `LANES`, 2: number of issue lanes (≥1); lane i occupies bits `[i*W +: W]` of every flat vector.
- `CNT_W`, 8: width of each illegal-instruction counter.
- `RESET_MODE`, 1'b0: mode after reset (1 = unified, 0 = split).
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: bundle valid.
- `in_ready` out 1: stage can accept.
- `in_lane_valid` in LANES: per-lane occupancy of the bundle.
- `in_instr` in 32*LANES: instruction words.
- `mode_i` in 1: requested mode (level).
- `mode_q` out 1: mode currently in effect.
- `mode_busy` out 1: high in DRAIN/SWITCH.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: downstream accepts.
- `out_lane_valid` out LANES: per-lane valid after mode masking.
- `out_alu_op` out 3*LANES: 000 add, 001 and, 010 or, 011 xor, 100 shift, 101 compare (slt/sltu).
- `out_alu_src` out LANES: 1 = immediate operand.
- `out_sub` out LANES: subtract (R-type SUB only).
- `out_shift_right` / `out_shift_arith` out LANES each.
- `out_mem_write` out LANES: store opcode.
- `out_branch` out LANES; `out_branch_type` out 3*LANES: beq 000, bne 001, blt 010, bge 011, bltu 100, bgeu 101.
- `out_illegal` out LANES: lane instruction not decodable.
- `illegal_cnt` out CNT_W*LANES: saturating per-lane counters.

## Operation
- Opcodes handled: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, JALR 1100111, BRANCH 1100011. Anything else sets illegal.
- Illegal also for: branch funct3 010/011; R-type funct7 outside {0000000, 0100000}; R-type funct7 0100000 with funct3 ∉ {000, 101}. Illegal lanes drive all other fields 0.
- alu_src = 1 for I/LOAD/STORE/JALR. LOAD/STORE/JALR/BRANCH force alu_op 000.
- Shifts: funct3 001 is a left shift. funct3 101 is a right shift, arithmetic when instr[30]=1 (R and I alike).
- Unified mode: only lane 0 decodes. out_lane_valid[LANES-1:1] forced 0, and those lanes' counters do not increment.
- FSM states NORMAL, DRAIN, SWITCH:
  - NORMAL → DRAIN when mode_i ≠ mode_q.
  - DRAIN → SWITCH when out_valid = 0, or when out_valid & out_ready.
  - SWITCH: mode_q ← current mode_i, then → NORMAL. A request that reverts during DRAIN is a no-op switch.
- Counter i increments on accept when the lane is valid (after masking) and illegal. It saturates at all-ones.

## Timing
- in_ready = (state==NORMAL) & (mode_i==mode_q) & (!out_valid | out_ready). This is combinational, with no bubble under sustained traffic.
- Accept at edge k → out_* valid from edge k, i.e. 1-cycle latency. Outputs hold stable while out_valid & !out_ready.
- Mode change with an empty pipe takes 2 cycles: DRAIN, then SWITCH. The first new-mode accept is possible in the cycle after SWITCH.
- Reset (async, at any time, including mid-drain):
  - out_valid=0 and all out_* fields 0.
  - counters 0; state NORMAL; mode_q=RESET_MODE.
  - An in-flight bundle is discarded.

## Structure
- Shared package: opcode/funct3/funct7 constants, alu_op and branch_type encodings, FSM state enum.
- One natural sub-module: `lane_decoder`. It is purely combinational, decoding a single 32-bit word into the control fields plus illegal, and is instantiated LANES times via generate. The FSM, output register and counters live in the top.

## Test plan
- LANES=2, split: lanes 0x40208033 (sub), 0x4020D093 (srai) → out_sub=01; lane 1: shift_right=1, shift_arith=1, alu_op=100, alu_src=1, after 1 cycle.
- Backpressure: out_ready=0 for 3 cycles with a bundle held → in_ready=0, out_* stable. Release → next bundle accepted in the same cycle.
- mode_i 0→1 while out_valid & !out_ready → DRAIN persists until out_ready, then SWITCH, then mode_q=1. A subsequent 2-lane bundle yields out_lane_valid=01.
- Lane 1 word 0xFFFFFFFF repeated 300 times at CNT_W=8 → out_illegal[1]=1, illegal_cnt lane 1 saturates at 255.
- Branch 0x00208663 (beq) and 0x0020E663 (bltu) → branch=1, branch_type 000/100, mem_write=0. Store 0x00112023 → mem_write=1, alu_src=1.
- Assert rst during DRAIN → out_valid=0 immediately, mode_q=RESET_MODE, counters 0, state NORMAL after release.
